// File: rtl/reg_file_np2r1w.sv
// Parametrised register file: one synchronous write port, two combinational read ports,
// sticky per-register written mask, optional zero register. Define REGFILE_BYPASS_EN for write-through forwarding.
module reg_file_np2r1w #(
    parameter int unsigned       NUM_REGS  = 4,
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       ADDR_W    = $clog2(NUM_REGS),
    parameter logic [DATA_W-1:0] RESET_VAL = {DATA_W{1'b0}},
    parameter bit                ZERO_REG  = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [ADDR_W-1:0]   rd_addr0,
    output logic [DATA_W-1:0]   rd_data0,
    input  logic [ADDR_W-1:0]   rd_addr1,
    output logic [DATA_W-1:0]   rd_data1,
    output logic [NUM_REGS-1:0] written_mask
);

    localparam int unsigned NUM_RD = 2;

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] wr_sel;
    logic [ADDR_W-1:0]   rd_addr [NUM_RD];

    assign rd_addr[0] = rd_addr0;
    assign rd_addr[1] = rd_addr1;

    // One-hot write select; a write to the zero register is dropped here so that
    // neither storage, mask nor forwarding ever sees it.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        wr_sel = '0;
        if (wr_en) begin
            wr_sel[wr_addr] = 1'b1;
        end
        if (ZERO_REG) begin
            wr_sel[0] = 1'b0;
        end
    end

    // NOTE: the register array is reset explicitly because its reset contents are
    // architecturally visible; a plain RAM macro could not offer this.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                // NOTE: non-blocking assignments for all clocked state, so every flop
                // samples pre-edge values regardless of process ordering.
                regs[i] <= RESET_VAL;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_sel[i]) begin
                    regs[i] <= wr_data;
                end
            end
        end
    end

    // Sticky until reset: OR-ing in the select keeps rewritten bits at 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            written_mask <= '0;
        end else begin
            written_mask <= written_mask | wr_sel;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [DATA_W-1:0] data;

        always_comb begin
            data = regs[rd_addr[p]];
            if (ZERO_REG && (rd_addr[p] == '0)) begin
                data = '0;
            end
`ifdef REGFILE_BYPASS_EN
            // wr_sel already excludes the zero register, so it is never forwarded.
            if (wr_sel[rd_addr[p]]) begin
                data = wr_data;
            end
`else
`endif
        end
    end

    assign rd_data0 = g_rd[0].data;
    assign rd_data1 = g_rd[1].data;

endmodule

// File: tb/tb_reg_file_np2r1w.sv
// Directed bench for reg_file_np2r1w: 4x32 plain, 4x32 with zero register, and 16x8 instances.
module tb_reg_file_np2r1w;

    logic clk;
    logic reset;

    // 4x32, ordinary register 0
    logic        a_wr_en;
    logic [1:0]  a_wr_addr;
    logic [31:0] a_wr_data;
    logic [1:0]  a_rd_addr0, a_rd_addr1;
    logic [31:0] a_rd_data0, a_rd_data1;
    logic [3:0]  a_mask;

    // 4x32, zero register
    logic        z_wr_en;
    logic [1:0]  z_wr_addr;
    logic [31:0] z_wr_data;
    logic [1:0]  z_rd_addr0, z_rd_addr1;
    logic [31:0] z_rd_data0, z_rd_data1;
    logic [3:0]  z_mask;

    // 16x8
    logic        w_wr_en;
    logic [3:0]  w_wr_addr;
    logic [7:0]  w_wr_data;
    logic [3:0]  w_rd_addr0, w_rd_addr1;
    logic [7:0]  w_rd_data0, w_rd_data1;
    logic [15:0] w_mask;

    int tests_run;
    int tests_failed;

    reg_file_np2r1w #(.NUM_REGS(4), .DATA_W(32)) u_dut_a (
        .clk(clk), .reset(reset),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .rd_addr0(a_rd_addr0), .rd_data0(a_rd_data0),
        .rd_addr1(a_rd_addr1), .rd_data1(a_rd_data1),
        .written_mask(a_mask)
    );

    reg_file_np2r1w #(.NUM_REGS(4), .DATA_W(32), .ZERO_REG(1'b1)) u_dut_z (
        .clk(clk), .reset(reset),
        .wr_en(z_wr_en), .wr_addr(z_wr_addr), .wr_data(z_wr_data),
        .rd_addr0(z_rd_addr0), .rd_data0(z_rd_data0),
        .rd_addr1(z_rd_addr1), .rd_data1(z_rd_data1),
        .written_mask(z_mask)
    );

    reg_file_np2r1w #(.NUM_REGS(16), .DATA_W(8)) u_dut_w (
        .clk(clk), .reset(reset),
        .wr_en(w_wr_en), .wr_addr(w_wr_addr), .wr_data(w_wr_data),
        .rd_addr0(w_rd_addr0), .rd_data0(w_rd_data0),
        .rd_addr1(w_rd_addr1), .rd_data1(w_rd_data1),
        .written_mask(w_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    logic [31:0] same_cycle_exp;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset = 1'b0;
        a_wr_en = 1'b0; a_wr_addr = '0; a_wr_data = '0; a_rd_addr0 = '0; a_rd_addr1 = '0;
        z_wr_en = 1'b0; z_wr_addr = '0; z_wr_data = '0; z_rd_addr0 = '0; z_rd_addr1 = '0;
        w_wr_en = 1'b0; w_wr_addr = '0; w_wr_data = '0; w_rd_addr0 = '0; w_rd_addr1 = '0;

        // Reset state, asserted between clock edges
        #1 reset = 1'b1;
        #2;
        check("rst_a_rd0", a_rd_data0, 32'h0);
        check("rst_a_rd1", a_rd_data1, 32'h0);
        check("rst_a_mask", 32'(a_mask), 32'h0);
        check("rst_z_mask", 32'(z_mask), 32'h0);
        check("rst_w_rd0", 32'(w_rd_data0), 32'h0);
        check("rst_w_mask", 32'(w_mask), 32'h0);

        // Reset wins over a write on the same edge
        a_wr_en = 1'b1; a_wr_addr = 2'd3; a_wr_data = 32'h5A5A_5A5A; a_rd_addr1 = 2'd3;
        @(posedge clk);
        #1 a_wr_en = 1'b0;
        #1;
        check("rst_wins_rd", a_rd_data1, 32'h0);
        check("rst_wins_mask", 32'(a_mask), 32'h0);
        @(negedge clk) reset = 1'b0;

        // Write reg2 and read it on both ports
        a_wr_en = 1'b1; a_wr_addr = 2'd2; a_wr_data = 32'hDEAD_BEEF;
        a_rd_addr0 = 2'd2; a_rd_addr1 = 2'd2;
`ifdef REGFILE_BYPASS_EN
        same_cycle_exp = 32'hDEAD_BEEF;
`else
        same_cycle_exp = 32'h0;
`endif
        #1 check("wr2_same_cycle", a_rd_data0, same_cycle_exp);
        @(posedge clk);
        #1 a_wr_en = 1'b0;
        #1;
        check("wr2_rd0", a_rd_data0, 32'hDEAD_BEEF);
        check("wr2_rd1", a_rd_data1, 32'hDEAD_BEEF);
        check("wr2_mask", 32'(a_mask), 32'h4);

        // Write reg1 while reading it in the same cycle
        @(negedge clk);
        a_wr_en = 1'b1; a_wr_addr = 2'd1; a_wr_data = 32'h1234_5678;
        a_rd_addr0 = 2'd1; a_rd_addr1 = 2'd2;
`ifdef REGFILE_BYPASS_EN
        same_cycle_exp = 32'h1234_5678;
`else
        same_cycle_exp = 32'h0;
`endif
        #1;
        check("wr1_same_cycle_rd0", a_rd_data0, same_cycle_exp);
        check("wr1_same_cycle_rd1", a_rd_data1, 32'hDEAD_BEEF);
        @(negedge clk);
        a_wr_en = 1'b0; a_wr_data = 32'hFFFF_FFFF;
        #1;
        check("wr1_rd0", a_rd_data0, 32'h1234_5678);
        check("wr1_mask", 32'(a_mask), 32'h6);

        // wr_en low: no state change across an edge
        @(negedge clk);
        #1;
        check("noen_rd0", a_rd_data0, 32'h1234_5678);
        check("noen_mask", 32'(a_mask), 32'h6);

        // Rewrite reg2: value updates, mask bit stays set
        a_wr_en = 1'b1; a_wr_addr = 2'd2; a_wr_data = 32'hCAFE_0001;
        @(negedge clk);
        a_wr_en = 1'b0;
        #1;
        check("rewr_rd1", a_rd_data1, 32'hCAFE_0001);
        check("rewr_mask", 32'(a_mask), 32'h6);

        // Zero register: write to reg0 dropped, reg3 write lands
        z_wr_en = 1'b1; z_wr_addr = 2'd0; z_wr_data = 32'hFFFF_FFFF;
        z_rd_addr0 = 2'd0; z_rd_addr1 = 2'd3;
        #1 check("zero_same_cycle", z_rd_data0, 32'h0);
        @(negedge clk);
        z_wr_addr = 2'd3; z_wr_data = 32'hAAAA_5555;
        #1;
        check("zero_rd0", z_rd_data0, 32'h0);
        check("zero_mask", 32'(z_mask), 32'h0);
        @(negedge clk);
        z_wr_en = 1'b0;
        #1;
        check("zero_rd3", z_rd_data1, 32'hAAAA_5555);
        check("zero_mask3", 32'(z_mask), 32'h8);

        // 16x8: reg15 then reg0 on consecutive edges
        w_wr_en = 1'b1; w_wr_addr = 4'd15; w_wr_data = 8'hA5;
        w_rd_addr0 = 4'd15; w_rd_addr1 = 4'd0;
        @(negedge clk);
        w_wr_addr = 4'd0; w_wr_data = 8'h3C;
        @(negedge clk);
        w_wr_en = 1'b0;
        #1;
        check("wide_rd15", 32'(w_rd_data0), 32'hA5);
        check("wide_rd0", 32'(w_rd_data1), 32'h3C);
        check("wide_mask", 32'(w_mask), 32'h8001);

        // Fill all four registers, then reset mid-cycle
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a_wr_en = 1'b1; a_wr_addr = 2'(i); a_wr_data = 32'(i) * 32'h1111_1111;
        end
        @(negedge clk);
        a_wr_en = 1'b0;
        a_rd_addr0 = 2'd3; a_rd_addr1 = 2'd1;
        #1;
        check("fill_rd3", a_rd_data0, 32'h3333_3333);
        check("fill_rd1", a_rd_data1, 32'h1111_1111);
        check("fill_mask", 32'(a_mask), 32'hF);
        #2 reset = 1'b1;
        #1;
        check("midrst_rd3", a_rd_data0, 32'h0);
        check("midrst_rd1", a_rd_data1, 32'h0);
        check("midrst_mask", 32'(a_mask), 32'h0);
        check("midrst_z_rd3", z_rd_data1, 32'h0);
        check("midrst_w_mask", 32'(w_mask), 32'h0);
        @(negedge clk) reset = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
